tpm_exec_bridge: RTL and testbench

- Transfer engine between the FIFO buffer stage and the command execution engine.
- On a command-send pulse it streams the command bytes out of the FIFO buffer into the execution engine over a valid/ready byte stream.
- It then signals execution-done to the FIFO, and writes the engine's response bytes back into the FIFO buffer using the FIFO's address/strobe protocol.

---
 rtl/tpm_io_pkg.sv | 10 +
 rtl/byte_skid_queue.sv | 29 ++
 rtl/tpm_exec_bridge.sv | 125 ++++++++++++
 tb/tb_tpm_exec_bridge.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tpm_io_pkg.sv
// tpm_io_pkg: shared sizes and FSM states for the FIFO <-> execution engine bridge
package tpm_io_pkg;
  localparam int BUF_SIZE = 4096;
  localparam int MIN_SIZE = 10;
  localparam int ADDR_W = $clog2(BUF_SIZE);
  localparam int IDX_W = ADDR_W + 1;
  typedef enum logic [2:0] {
    IDLE, CMD_RUN, CMD_DONE, EXEC_WAIT, EXEC_PULSE, RSP_ARM, RSP_RUN, RSP_DONE
  } state_t;
endpackage

// File: rtl/byte_skid_queue.sv
// byte_skid_queue: 2-entry byte FIFO absorbing the buffer's 1-cycle read latency
module byte_skid_queue (
  input  logic       clock,
  input  logic       reset,
  input  logic       pushValid,
  input  logic [7:0] pushData,
  input  logic       popReady,
  output logic       popValid,
  output logic [7:0] popData,
  output logic [1:0] count
);
  logic [7:0] mem [2];
  logic wrPtr, rdPtr, doPop;
  assign popValid = count != 2'd0;
  assign popData = mem[rdPtr];
  assign doPop = popValid && popReady;
  always_ff @(posedge clock)
    if (pushValid) mem[wrPtr] <= pushData;
  always_ff @(posedge clock)
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pushValid) wrPtr <= !wrPtr;
      if (doPop) rdPtr <= !rdPtr;
      count <= count + {1'b0, pushValid} - {1'b0, doPop};
    end
endmodule

// File: rtl/tpm_exec_bridge.sv
// tpm_exec_bridge: streams commands from the FIFO buffer to the engine and writes responses back
module tpm_exec_bridge
  import tpm_io_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              f_abort,
  input  logic              c_cmdSend,
  input  logic [31:0]       c_cmdSize,
  input  logic [7:0]        cmdByteOut,
  output logic [ADDR_W-1:0] c_cmdInAddr,
  output logic              c_cmdDone,
  output logic              e_execDone,
  output logic [31:0]       c_rspSize,
  output logic [ADDR_W-1:0] c_rspInAddr,
  output logic [7:0]        rspByteIn,
  output logic              c_rspSend,
  output logic              c_rspDone,
  output logic              x_cmdValid,
  input  logic              x_cmdReady,
  output logic [7:0]        x_cmdByte,
  output logic              x_cmdLast,
  output logic              x_cmdStart,
  output logic [ADDR_W-1:0] x_cmdSize,
  output logic              x_cmdErr,
  input  logic              x_rspStart,
  input  logic [31:0]       x_rspSize,
  input  logic              x_rspValid,
  output logic              x_rspReady,
  input  logic [7:0]        x_rspByte,
  output logic              x_rspOvf
);
  state_t state, nxt;
  logic [IDX_W-1:0] cmdLen, rdIdx, sentIdx, wrIdx;
  logic [31:0] rspLeft, rspSizeR;
  logic [1:0] qCnt;
  logic [7:0] qData;
  logic qValid, inFlight, execArmed, armCnt, startR, cmdErr, rspOvf;
  logic clr, run, legal, pop, cmdLast, issue, rspAcc, wr, rspBegin;
  assign clr = reset || f_abort;
  assign run = state == CMD_RUN;
  assign legal = c_cmdSize >= MIN_SIZE && c_cmdSize <= BUF_SIZE;
  assign pop = run && qValid && x_cmdReady;
  assign cmdLast = sentIdx == cmdLen - 1'b1;
  // the in-flight read already owns a queue slot; a same-cycle pop frees one
  assign issue = run && rdIdx < cmdLen && ({1'b0, qCnt} + {2'b0, inFlight}) < (3'd2 + {2'b0, pop});
  assign rspAcc = state == RSP_RUN && x_rspValid;
  assign wr = rspAcc && wrIdx < IDX_W'(BUF_SIZE);
  assign rspBegin = state == EXEC_WAIT && execArmed && x_rspStart;
  assign c_cmdInAddr = rdIdx[ADDR_W-1:0];
  assign c_cmdDone = state == CMD_DONE;
  assign e_execDone = state == EXEC_PULSE;
  assign c_rspSize = rspSizeR;
  assign c_rspInAddr = wrIdx[ADDR_W-1:0];
  assign rspByteIn = wr ? x_rspByte : 8'h00;
  assign c_rspSend = !wr;
  assign c_rspDone = state == RSP_DONE;
  assign x_cmdValid = run && qValid;
  assign x_cmdByte = qData;
  assign x_cmdLast = x_cmdValid && cmdLast;
  assign x_cmdStart = startR;
  assign x_cmdSize = cmdLen[ADDR_W-1:0];
  assign x_cmdErr = cmdErr;
  assign x_rspReady = state == RSP_RUN;
  assign x_rspOvf = rspOvf;
  byte_skid_queue u_queue (
    .clock(clock), .reset(clr), .pushValid(inFlight), .pushData(cmdByteOut),
    .popReady(run && x_cmdReady), .popValid(qValid), .popData(qData), .count(qCnt)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = c_cmdSend ? (legal ? CMD_RUN : CMD_DONE) : IDLE;
      CMD_RUN:    nxt = pop && cmdLast ? CMD_DONE : CMD_RUN;
      CMD_DONE:   nxt = EXEC_WAIT;
      EXEC_WAIT:  nxt = rspBegin ? EXEC_PULSE : EXEC_WAIT;
      EXEC_PULSE: nxt = RSP_ARM;
      RSP_ARM:    nxt = !armCnt ? RSP_ARM : rspLeft == 32'd0 ? RSP_DONE : RSP_RUN;
      RSP_RUN:    nxt = rspAcc && rspLeft == 32'd1 ? RSP_DONE : RSP_RUN;
      RSP_DONE:   nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (clr) begin
      state <= IDLE;
      cmdLen <= '0;
      rdIdx <= '0;
      sentIdx <= '0;
      wrIdx <= '0;
      rspLeft <= '0;
      rspSizeR <= '0;
      inFlight <= 1'b0;
      execArmed <= 1'b0;
      armCnt <= 1'b0;
      startR <= 1'b0;
      cmdErr <= 1'b0;
      rspOvf <= 1'b0;
    end else begin
      state <= nxt;
      startR <= state == IDLE && c_cmdSend && legal;
      inFlight <= issue;
      execArmed <= state == EXEC_WAIT;
      armCnt <= state == RSP_ARM && !armCnt;
      if (state == IDLE && c_cmdSend) begin
        cmdLen <= legal ? c_cmdSize[IDX_W-1:0] : '0;
        rdIdx <= '0;
        sentIdx <= '0;
        cmdErr <= !legal;
        rspOvf <= 1'b0;
      end else begin
        rdIdx <= rdIdx + IDX_W'(issue);
        sentIdx <= sentIdx + IDX_W'(pop);
      end
      if (rspBegin) begin
        rspLeft <= x_rspSize;
        rspSizeR <= x_rspSize > BUF_SIZE ? 32'(BUF_SIZE) : x_rspSize;
        rspOvf <= x_rspSize > BUF_SIZE;
        wrIdx <= '0;
      end else begin
        rspLeft <= rspLeft - 32'(rspAcc);
        wrIdx <= wrIdx + IDX_W'(wr);
      end
    end
endmodule

// File: tb/tb_tpm_exec_bridge.sv
// tb_tpm_exec_bridge: randomized transactions checked against a transaction-level model
module tb_tpm_exec_bridge;
  logic clock = 0, reset = 1, f_abort = 0, c_cmdSend = 0;
  logic [31:0] c_cmdSize = 0, x_rspSize = 0, c_rspSize;
  logic [7:0] cmdByteOut = 0, rspByteIn, x_cmdByte, x_rspByte = 0;
  logic [11:0] c_cmdInAddr, c_rspInAddr, x_cmdSize;
  logic c_cmdDone, e_execDone, c_rspSend, c_rspDone, x_cmdValid, x_cmdReady = 0;
  logic x_cmdLast, x_cmdStart, x_cmdErr, x_rspStart = 0, x_rspValid = 0, x_rspReady, x_rspOvf;
  logic [7:0] bufMem [4096];
  int total = 0, bad = 0, cyc = 0;
  int sendCyc, expSize, cmdIdx, firstCmdCyc, lastCmdCyc, startCnt, startCyc, cmdDoneCnt, cmdDoneCyc;
  int execCnt, eCyc = -100, rspAcc, wrCnt, firstWrCyc, lastRspCyc, rspDoneCnt, rspDoneCyc;
  int rspSeed, rspStartCyc;
  bit expectCmd, acc, wrExp;
  tpm_exec_bridge dut (
    .clock(clock), .reset(reset), .f_abort(f_abort), .c_cmdSend(c_cmdSend), .c_cmdSize(c_cmdSize),
    .cmdByteOut(cmdByteOut), .c_cmdInAddr(c_cmdInAddr), .c_cmdDone(c_cmdDone), .e_execDone(e_execDone),
    .c_rspSize(c_rspSize), .c_rspInAddr(c_rspInAddr), .rspByteIn(rspByteIn), .c_rspSend(c_rspSend),
    .c_rspDone(c_rspDone), .x_cmdValid(x_cmdValid), .x_cmdReady(x_cmdReady), .x_cmdByte(x_cmdByte),
    .x_cmdLast(x_cmdLast), .x_cmdStart(x_cmdStart), .x_cmdSize(x_cmdSize), .x_cmdErr(x_cmdErr),
    .x_rspStart(x_rspStart), .x_rspSize(x_rspSize), .x_rspValid(x_rspValid), .x_rspReady(x_rspReady),
    .x_rspByte(x_rspByte), .x_rspOvf(x_rspOvf)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) cmdByteOut <= bufMem[c_cmdInAddr];
  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + rspSeed) & 255);
  endfunction
  function automatic logic rdy(input int m, input int k);
    return m == 1 ? 1'b1 : m == 2 ? 1'(k % 2 == 0) : 1'($urandom_range(0, 1));
  endfunction
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      if (c_cmdSend) begin
        sendCyc = cyc;
        expSize = c_cmdSize;
        expectCmd = c_cmdSize >= 10 && c_cmdSize <= 4096;
        cmdIdx = 0; firstCmdCyc = -1; startCnt = 0; cmdDoneCnt = 0;
        execCnt = 0; eCyc = -100; rspAcc = 0; wrCnt = 0; firstWrCyc = -1; rspDoneCnt = 0;
      end
      if (x_cmdValid) check("cmd_valid_allowed", expectCmd, 1);
      if (x_cmdValid && x_cmdReady) begin
        check("cmd_byte", x_cmdByte, bufMem[cmdIdx % 4096]);
        check("cmd_last", x_cmdLast, cmdIdx == expSize - 1);
        if (firstCmdCyc < 0) firstCmdCyc = cyc;
        lastCmdCyc = cyc;
        cmdIdx++;
      end
      if (x_cmdStart) begin
        startCnt++;
        startCyc = cyc;
        check("cmd_size_out", x_cmdSize, expSize % 4096);
      end
      if (c_cmdDone) begin cmdDoneCnt++; cmdDoneCyc = cyc; end
      if (e_execDone) begin execCnt++; eCyc = cyc; end
      if (cyc == eCyc + 1 || cyc == eCyc + 2) check("rsp_ready_arm", x_rspReady, 0);
      acc = x_rspValid && x_rspReady;
      wrExp = acc && rspAcc < 4096;
      if (wrExp || !c_rspSend) check("rsp_strobe", !c_rspSend, wrExp);
      if (wrExp) begin
        check("rsp_addr", c_rspInAddr, rspAcc % 4096);
        check("rsp_data", rspByteIn, pat(rspAcc));
        if (firstWrCyc < 0) firstWrCyc = cyc;
      end
      if (!c_rspSend) wrCnt++;
      if (acc) begin rspAcc++; lastRspCyc = cyc; end
      if (c_rspDone) begin rspDoneCnt++; rspDoneCyc = cyc; end
      if (f_abort) expectCmd = 0;
    end
  end
  task automatic txn(input int cSize, input int rMode, input int rSize, input int vMode, input bit early);
    int k, wrWant;
    bit legal;
    legal = cSize >= 10 && cSize <= 4096;
    wrWant = rSize > 4096 ? 4096 : rSize;
    rspSeed = $urandom_range(0, 255);
    @(posedge clock); #1;
    c_cmdSend = 1; c_cmdSize = cSize; x_cmdReady = rdy(rMode, 0);
    @(posedge clock); #1;
    c_cmdSend = 0; c_cmdSize = $urandom;
    k = 1;
    while (cmdDoneCnt == 0 && k < 20000) begin
      x_cmdReady = rdy(rMode, k);
      @(posedge clock); #1;
      k++;
    end
    x_cmdReady = 0;
    check("cmd_done_cnt", cmdDoneCnt, 1);
    check("cmd_bytes", cmdIdx, legal ? cSize : 0);
    check("cmd_start_cnt", startCnt, legal);
    check("cmd_err", x_cmdErr, !legal);
    if (legal) check("cmd_start_cyc", startCyc, sendCyc + 1);
    else check("cmd_done_cyc", cmdDoneCyc, sendCyc + 1);
    if (legal && rMode == 1) check("cmd_streaming", lastCmdCyc - firstCmdCyc, cSize - 1);
    if (early) begin
      x_rspStart = 1; x_rspSize = rSize;
      @(posedge clock); #1;
      x_rspStart = 0;
      repeat (2) @(posedge clock);
      #1;
      check("early_start_ignored", execCnt, 0);
    end else begin
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
    end
    x_rspStart = 1; x_rspSize = rSize; rspStartCyc = cyc;
    @(posedge clock); #1;
    x_rspStart = 0; x_rspSize = $urandom;
    k = 0;
    while (rspDoneCnt == 0 && k < 20000) begin
      x_rspValid = rspAcc < rSize && (vMode == 0 || $urandom_range(0, 1) == 1);
      x_rspByte = pat(rspAcc);
      @(posedge clock); #1;
      k++;
    end
    x_rspValid = 0;
    check("exec_done_cnt", execCnt, 1);
    check("exec_done_cyc", eCyc, rspStartCyc + 1);
    check("rsp_accepted", rspAcc, rSize);
    check("rsp_writes", wrCnt, wrWant);
    check("rsp_size", c_rspSize, wrWant);
    check("rsp_ovf", x_rspOvf, rSize > 4096);
    check("rsp_done_cnt", rspDoneCnt, 1);
    if (rSize > 0) begin
      check("rsp_first_write_late", firstWrCyc >= eCyc + 3, 1);
      check("rsp_done_cyc", rspDoneCyc, lastRspCyc + 1);
    end else check("rsp_done_empty_cyc", rspDoneCyc, eCyc + 3);
  endtask
  initial begin
    int k;
    for (int i = 0; i < 4096; i++) bufMem[i] = 8'($urandom);
    repeat (3) @(posedge clock);
    #1;
    check("rst_rspSend", c_rspSend, 1);
    check("rst_cmdAddr", c_cmdInAddr, 0);
    check("rst_rspAddr", c_rspInAddr, 0);
    check("rst_rspSize", c_rspSize, 0);
    check("rst_cmdValid", x_cmdValid, 0);
    check("rst_cmdErr", x_cmdErr, 0);
    check("rst_rspOvf", x_rspOvf, 0);
    check("rst_pulses", {c_cmdDone, e_execDone, c_rspDone, x_cmdStart}, 0);
    check("rst_rspReady", x_rspReady, 0);
    reset = 0;
    txn(12, 1, 10, 0, 0);
    check("lit_cmd12", cmdIdx, 12);
    check("lit_rsp10_size", c_rspSize, 10);
    check("lit_rsp10_writes", wrCnt, 10);
    txn(12, 2, 10, 1, 0);
    check("lit_toggle_cmd12", cmdIdx, 12);
    txn(5, 0, 0, 0, 0);
    check("lit_err5", x_cmdErr, 1);
    check("lit_err5_bytes", cmdIdx, 0);
    txn(9, 1, 3, 1, 1);
    txn(10, 2, 10, 1, 0);
    check("lit_err_cleared", x_cmdErr, 0);
    txn(4097, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      txn($urandom_range(10, 40), $urandom_range(0, 2), $urandom_range(0, 40), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    txn(20, 1, 5000, 0, 0);
    check("lit_ovf_size", c_rspSize, 4096);
    check("lit_ovf_flag", x_rspOvf, 1);
    check("lit_ovf_writes", wrCnt, 4096);
    check("lit_ovf_accepted", rspAcc, 5000);
    @(posedge clock); #1;
    c_cmdSend = 1; c_cmdSize = 12; x_cmdReady = 1;
    @(posedge clock); #1;
    c_cmdSend = 0;
    k = 0;
    while (cmdIdx < 5 && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    x_cmdReady = 0; f_abort = 1;
    @(posedge clock); #1;
    f_abort = 0;
    check("abort_valid", x_cmdValid, 0);
    check("abort_addr", c_cmdInAddr, 0);
    check("abort_strobe", c_rspSend, 1);
    x_cmdReady = 1;
    repeat (6) @(posedge clock);
    #1;
    check("abort_no_done", cmdDoneCnt, 0);
    check("abort_bytes", cmdIdx, 5);
    x_cmdReady = 0;
    txn(12, 1, 10, 0, 0);
    check("lit_restart_cmd12", cmdIdx, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
